alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that performs a WIDTH-bit ALU operation by driving one external registered 1-bit ALU slice LSB-first, one bit per clock. It chains the carry between bits using the slice's registered carry output, and assembles the result word. It derives the carry, overflow, zero and set-less-than results. A start/busy/done handshake lets a host issue one operation at a time.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
func  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result/flags valid
err  output  1  high with done when func was illegal; held until next accept
result  output  WIDTH  final result, held until next accepted start
carry_out  output  1  MSB carry for ADD/SUB (SUB: 1 = no borrow); 0 for other ops
overflow  output  1  signed overflow for ADD/SUB/SLT; 0 otherwise
zero  output  1  result == 0
alu_inA  output  1  bit of A to slice
alu_inB  output  1  bit of B to slice
alu_Cin  output  1  carry-in to slice
alu_binv  output  1  B-invert to slice
alu_less  output  1  tied 0 (slice compare op unused)
alu_op  output  2  slice op: 00 AND, 01 OR, 10 add
alu_result  input  1  slice result, registered by slice (1-cycle latency)
alu_Cout  input  1  slice carry, registered by slice; valid only after an op=10 cycle

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE. busy = (state != IDLE).
- Reset (synchronous): state IDLE, idx 0; busy, done, err, result, carry_out, overflow and zero all 0; all alu_* outputs 0.
- IDLE: when start=1 with a legal func, latch a, b, func; clear err; idx=0; go to ISSUE. When start=1 with an illegal func, set result=0 and err=1 and go directly to DONE. When start=0, drive alu_* to 0.
- ISSUE (WIDTH cycles, idx 0..WIDTH-1): drive the slice combinationally:
  - alu_inA = A[idx] and alu_inB = B[idx].
  - alu_op = 00 for AND, 01 for OR, 10 for ADD/SUB/SLT.
  - alu_binv = 1 for SUB/SLT, otherwise 0.
  - alu_Cin: at idx 0 it is 1 for SUB/SLT, else 0; at idx>0 it is alu_Cout.
  - At idx = WIDTH-1, latch msb_cin = alu_Cin.
  - For idx >= 1, capture alu_result into result bit idx-1.
- ISSUE to DRAIN when idx = WIDTH-1.
- DRAIN (1 cycle): capture alu_result into bit WIDTH-1; latch c = alu_Cout; drive alu_* to 0.
- DRAIN to DONE, with output results registered:
  - ADD/SUB: carry_out = c; overflow = c ^ msb_cin; result = sum.
  - SLT: result = {0..., sum[WIDTH-1] ^ (c ^ msb_cin)}; overflow = c ^ msb_cin; carry_out = 0.
  - AND/OR: carry_out = 0; overflow = 0.
  - zero = (final result == 0).
- DONE (1 cycle): done=1, then go to IDLE. start is ignored in DONE.
- Latency, legal func: start accepted at edge E0, done high during the cycle after edge E0+WIDTH+1, i.e. WIDTH+2 cycles per operation. Host can restart the cycle after done.
- Latency, illegal func: done high in the cycle after the accept edge; no slice activity.
- start while busy is ignored; latched operands are unaffected by a/b/func changes after accept.
- alu_Cout is never consumed before bit 0 has been issued with op=10, so the slice's unreset carry is harmless.
- Reset asserted mid-operation: abort to IDLE next edge with all outputs cleared; partial result discarded; no done pulse.
- Signed interpretation (two's complement) applies to overflow/SLT only; ADD/SUB wrap mod 2^WIDTH.

Test Plan:
- WIDTH=4, with the bench containing a behavioural model of the registered slice (1-cycle result/carry; Cout updates only on op=10).
- ADD a=0101 b=0011 -> done exactly 6 cycles after start edge; result 1000, carry_out 0, overflow 1, zero 0.
- ADD a=1111 b=0001 -> result 0000, carry_out 1, overflow 0, zero 1.
- SUB a=0011 b=0101 -> result 1110, carry_out 0, overflow 0. SUB a=0101 b=0101 -> result 0000, carry_out 1, zero 1.
- SLT a=0011 b=0101 -> 0001. SLT a=1000 b=0111 (-8<7) -> 0001, overflow 1. SLT a=0111 b=1000 -> 0000, zero 1.
- AND 1100&1010 -> 1000; OR 1100|1010 -> 1110; both with carry_out 0 and overflow 0. Illegal func 011 -> done one cycle after accept, err 1, result 0000.
- Pulse start again during ISSUE with different operands -> ignored, first result intact. Assert reset during ISSUE idx 2 -> next cycle busy 0, result 0, no done pulse; a following ADD completes correctly.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
//   Bit-serial sequencer that runs a WIDTH-bit ALU operation through one
//   external registered 1-bit ALU slice. Bits are issued LSB first, one per
//   clock. The carry is chained through the slice's registered carry output.
//   The result word is assembled here, and carry/overflow/zero/SLT are derived
//   at the end.
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   start, func, a, b     operation request (func: 000 AND, 001 OR, 010 ADD,
//                         110 SUB, 111 SLT; anything else is illegal)
//   busy, done, err       status (busy = not idle, done = 1-cycle pulse)
//   result, carry_out,
//   overflow, zero        final result word and flags, held until next accept
//   alu_inA/inB/Cin/binv/
//   less/op               drive to the 1-bit slice
//   alu_result, alu_Cout  registered slice outputs (1-cycle latency)
//   state_dbg             current FSM state for observation
//
// Handshake: a request is taken when start=1 while busy=0 (IDLE). a, b and
// func are captured on that edge. done pulses for exactly one cycle when
// result and flags are valid. busy then drops on the following edge, and a new
// start can be taken in that same cycle. start while busy is ignored.

module alu_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             alu_inA,
    output logic             alu_inB,
    output logic             alu_Cin,
    output logic             alu_binv,
    output logic             alu_less,
    output logic [1:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_Cout,
    output logic [1:0]       state_dbg
);

    localparam int IDXW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       func_q;
    logic             msb_cin;
    logic [WIDTH-2:0] sum_q;   // bits 0..WIDTH-2; the MSB arrives in DRAIN

    logic             legal;
    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] final_sum;
    logic             ovf;
    logic [WIDTH-1:0] final_res;

    assign legal = (func == F_AND) || (func == F_OR) || (func == F_ADD) ||
                   (func == F_SUB) || (func == F_SLT);
    assign is_sub   = (func_q == F_SUB) || (func_q == F_SLT);
    assign is_arith = is_sub || (func_q == F_ADD);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;
    assign alu_less  = 1'b0;

    // Slice drive: active only while bits are being issued.
    always_comb begin
        alu_inA  = 1'b0;
        alu_inB  = 1'b0;
        alu_Cin  = 1'b0;
        alu_binv = 1'b0;
        alu_op   = 2'b00;
        if (state == S_ISSUE && !reset) begin
            alu_inA  = a_q[idx];
            alu_inB  = b_q[idx];
            alu_binv = is_sub;
            alu_op   = is_arith ? 2'b10 : ((func_q == F_OR) ? 2'b01 : 2'b00);
            // Bit 0 takes the subtract carry-in; later bits chain the slice carry.
            alu_Cin  = (idx == '0) ? is_sub : alu_Cout;
        end
    end

    // Final word while in DRAIN: MSB comes straight from the slice this cycle.
    always_comb begin
        final_sum = {alu_result, sum_q};
        ovf       = alu_Cout ^ msb_cin;
        final_res = final_sum;
        if (func_q == F_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, final_sum[WIDTH-1] ^ ovf};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            msb_cin   <= 1'b0;
            sum_q     <= '0;
            err       <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (legal) begin
                            a_q    <= a;
                            b_q    <= b;
                            func_q <= func;
                            err    <= 1'b0;
                            idx    <= '0;
                            state  <= S_ISSUE;
                        end else begin
                            result    <= '0;
                            err       <= 1'b1;
                            carry_out <= 1'b0;
                            overflow  <= 1'b0;
                            zero      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Slice result lags by one cycle, so bit idx-1 arrives now.
                    if (idx != '0) begin
                        sum_q[idx - IDXW'(1)] <= alu_result;
                    end
                    if (idx == IDXW'(WIDTH-1)) begin
                        msb_cin <= alu_Cin;
                        state   <= S_DRAIN;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_DRAIN: begin
                    result <= final_res;
                    zero   <= (final_res == '0);
                    if (is_arith) begin
                        overflow  <= ovf;
                        carry_out <= (func_q == F_SLT) ? 1'b0 : alu_Cout;
                    end else begin
                        overflow  <= 1'b0;
                        carry_out <= 1'b0;
                    end
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;
    localparam logic [2:0] F_BAD = 3'b011;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] func  = 3'b000;
    logic [3:0] a     = 4'h0;
    logic [3:0] b     = 4'h0;
    logic       busy, done, err, carry_out, overflow, zero;
    logic [3:0] result;
    logic       alu_inA, alu_inB, alu_Cin, alu_binv, alu_less;
    logic [1:0] alu_op;
    logic       alu_result = 1'b0;
    logic       alu_Cout   = 1'b0;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Clock / reset
    always #5 clock = ~clock;

    alu_serial_ctrl #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .func(func), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_Cin(alu_Cin),
        .alu_binv(alu_binv), .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(alu_result), .alu_Cout(alu_Cout), .state_dbg(state_dbg)
    );

    // Registered 1-bit slice: result every cycle, carry only on add cycles.
    logic slice_b;
    assign slice_b = alu_inB ^ alu_binv;
    always @(posedge clock) begin
        case (alu_op)
            2'b00:   alu_result <= alu_inA & slice_b;
            2'b01:   alu_result <= alu_inA | slice_b;
            default: alu_result <= alu_inA ^ slice_b ^ alu_Cin;
        endcase
        if (alu_op == 2'b10)
            alu_Cout <= (alu_inA & slice_b) | (alu_inA & alu_Cin) | (slice_b & alu_Cin);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Driver: issue one op, scramble inputs after accept, wait for done.
    // lat = cycles after the accept edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [2:0] f, input logic [3:0] x, input logic [3:0] y,
                          output int lat, output logic busy0, output logic [1:0] op0,
                          output logic binv0, output logic cin0);
        start = 1'b1; func = f; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        a     = 4'($urandom_range(0, 15));
        b     = 4'($urandom_range(0, 15));
        func  = 3'($urandom_range(0, 7));
        busy0 = busy; op0 = alu_op; binv0 = alu_binv; cin0 = alu_Cin;
        lat = -1;
        for (int i = 0; i <= 12; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    typedef struct {
        string      name;
        logic [2:0] f;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] res;
        logic       cy;
        logic       ov;
        logic       zf;
        logic       er;
        int         lat;
        logic [1:0] op0;
        logic       binv0;
        logic       cin0;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int         lat;
        logic       busy0, binv0, cin0;
        logic [1:0] op0;
        logic       seen;

        vecs[0]  = '{"add_ovf",  F_ADD, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 5, 2'b10, 1'b0, 1'b0};
        vecs[1]  = '{"add_wrap", F_ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 5, 2'b10, 1'b0, 1'b0};
        vecs[2]  = '{"sub_neg",  F_SUB, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2'b10, 1'b1, 1'b1};
        vecs[3]  = '{"sub_eq",   F_SUB, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 5, 2'b10, 1'b1, 1'b1};
        vecs[4]  = '{"slt_lt",   F_SLT, 4'b0011, 4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2'b10, 1'b1, 1'b1};
        vecs[5]  = '{"slt_ovf1", F_SLT, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 5, 2'b10, 1'b1, 1'b1};
        vecs[6]  = '{"slt_ovf0", F_SLT, 4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 5, 2'b10, 1'b1, 1'b1};
        vecs[7]  = '{"and",      F_AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{"or",       F_OR,  4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2'b01, 1'b0, 1'b0};
        vecs[9]  = '{"illegal",  F_BAD, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{"add_plain",F_ADD, 4'b0110, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2'b10, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_result", 32'(result), 0);
        check("rst_flags", {29'd0, carry_out, overflow, zero}, 0);
        check("rst_alu_drive", {26'd0, alu_inA, alu_inB, alu_Cin, alu_binv, alu_less, alu_op}, 0);
        check("rst_state", 32'(state_dbg), 0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].x, vecs[i].y, lat, busy0, op0, binv0, cin0);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].res));
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].er));
            check({vecs[i].name, "_op0"}, 32'(op0), 32'(vecs[i].op0));
            if (vecs[i].er == 1'b0) begin
                check({vecs[i].name, "_busy0"}, 32'(busy0), 1);
                check({vecs[i].name, "_cy"}, 32'(carry_out), 32'(vecs[i].cy));
                check({vecs[i].name, "_ov"}, 32'(overflow), 32'(vecs[i].ov));
                check({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].zf));
                check({vecs[i].name, "_binv0"}, 32'(binv0), 32'(vecs[i].binv0));
                check({vecs[i].name, "_cin0"}, 32'(cin0), 32'(vecs[i].cin0));
            end
            @(posedge clock); #1;
            check({vecs[i].name, "_done_pulse"}, 32'(done), 0);
            check({vecs[i].name, "_idle_after"}, 32'(busy), 0);
        end

        // start pulsed during ISSUE must be ignored
        start = 1'b1; func = F_ADD; a = 4'b0101; b = 4'b0011;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; func = F_SUB; a = 4'b1111; b = 4'b1111;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("busy_start_done", 32'(seen), 1);
        check("busy_start_result", 32'(result), 32'(4'b1000));
        check("busy_start_ov", 32'(overflow), 1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (busy) seen = 1'b1;
        end
        check("busy_start_no_second_op", 32'(seen), 0);

        // Reset during ISSUE idx 2
        start = 1'b1; func = F_ADD; a = 4'b0110; b = 4'b0001;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_reset_idx2_busy", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_result", 32'(result), 0);
        check("abort_done", 32'(done), 0);
        check("abort_alu_op", 32'(alu_op), 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen = 1'b1;
            @(posedge clock); #1;
        end
        check("abort_no_done", 32'(seen), 0);
        run_op(F_ADD, 4'b0110, 4'b0001, lat, busy0, op0, binv0, cin0);
        check("post_abort_lat", 32'(lat), 5);
        check("post_abort_result", 32'(result), 32'(4'b0111));
        check("post_abort_flags", {29'd0, carry_out, overflow, zero}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
